// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: PC-1 on load, then one 48-bit round key per output handshake.
// Encrypt walks K1..K16 by left rotation; decrypt walks K16..K1 by right rotation from C0/D0.

module perm2 (
  input  logic [55:0] cd,
  output logic [47:0] rk
);
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Table entries use FIPS numbering: bit 1 is the MSB of {C,D}.
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign rk[47-i] = cd[56-PC2[i]];
  end
endmodule

module des_key_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [47:0] rk_o,
  output logic [3:0]  rk_round_o,
  output logic        rk_last_o,
  output logic        busy_o
);
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic        mode;
  logic [27:0] c, d;
  logic [55:0] cd0;
  logic [27:0] next_c, next_d;
  logic [47:0] next_rk;
  logic [4:0]  sched_idx;
  logic        double_shift;
  logic        parity_unused;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd0[55-i] = key_i[64-PC1[i]];
  end

  assign parity_unused = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                           key_i[24], key_i[16], key_i[8],  key_i[0]};

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Encrypt advances to round n+2 of the FIPS table; decrypt undoes round 16-n.
  assign sched_idx    = mode ? (5'd16 - {1'b0, rk_round_o}) : ({1'b0, rk_round_o} + 5'd2);
  assign double_shift = !(sched_idx == 5'd1 || sched_idx == 5'd2 ||
                          sched_idx == 5'd9 || sched_idx == 5'd16);

  always_comb begin
    next_c = c;
    next_d = d;
    if (state == IDLE) begin
      next_c = decrypt_i ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
      next_d = decrypt_i ? cd0[27:0]  : rotl(cd0[27:0],  1'b0);
    end else if (mode) begin
      next_c = rotr(c, double_shift);
      next_d = rotr(d, double_shift);
    end else begin
      next_c = rotl(c, double_shift);
      next_d = rotl(d, double_shift);
    end
  end

  perm2 u_perm2 (
    .cd ({next_c, next_d}),
    .rk (next_rk)
  );

  assign key_ready_o = (state == IDLE);
  assign busy_o      = (state == EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      c          <= '0;
      d          <= '0;
      rk_o       <= '0;
      rk_round_o <= '0;
      rk_valid_o <= 1'b0;
      rk_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid_i) begin
            mode       <= decrypt_i;
            c          <= next_c;
            d          <= next_d;
            rk_o       <= next_rk;
            rk_round_o <= 4'd0;
            rk_valid_o <= 1'b1;
            rk_last_o  <= 1'b0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready_i) begin
            if (rk_round_o == 4'd15) begin
              rk_valid_o <= 1'b0;
              rk_last_o  <= 1'b0;
              state      <= IDLE;
            end else begin
              c          <= next_c;
              d          <= next_d;
              rk_o       <= next_rk;
              rk_round_o <= rk_round_o + 4'd1;
              rk_last_o  <= (rk_round_o == 4'd14);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: directed and random keys against a cumulative-shift key schedule model.
module tb_des_key_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid_i = 1'b0;
  logic        key_ready_o;
  logic [63:0] key_i = '0;
  logic        decrypt_i = 1'b0;
  logic        rk_valid_o;
  logic        rk_ready_i = 1'b0;
  logic [47:0] rk_o;
  logic [3:0]  rk_round_o;
  logic        rk_last_o;
  logic        busy_o;

  des_key_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .key_i       (key_i),
    .decrypt_i   (decrypt_i),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .rk_o        (rk_o),
    .rk_round_o  (rk_round_o),
    .rk_last_o   (rk_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [47:0] exp_rk  [16];
  logic [47:0] cap     [16];
  logic [47:0] cap_enc [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round r key uses C0/D0 rotated left by the cumulative FIPS shift; decrypt is that list reversed.
  function automatic void build(input logic [63:0] k, input bit dec);
    logic [27:0] c0, d0, cr, dr;
    logic [55:0] cd;
    logic [47:0] enc [16];
    int          total = 0;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = k[64-PC1[i]];
      d0[27-i] = k[64-PC1[28+i]];
    end
    for (int r = 1; r <= 16; r++) begin
      total += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      cr = 28'(({c0, c0} >> (28 - total)));
      dr = 28'(({d0, d0} >> (28 - total)));
      cd = {cr, dr};
      for (int j = 0; j < 48; j++) enc[r-1][47-j] = cd[56-PC2[j]];
    end
    for (int i = 0; i < 16; i++) exp_rk[i] = dec ? enc[15-i] : enc[i];
  endfunction

  task automatic accept();
    int b = 0;
    key_valid_i = 1'b1;
    while (key_ready_o !== 1'b1 && b < 100) begin
      @(posedge clk); #1; b++;
    end
    chk("accept_ready", key_ready_o, 1);
    @(posedge clk); #1;
    key_valid_i = 1'b0;
  endtask

  task automatic collect(input int stop_at, input int stall_pct);
    int got = 0;
    int budget = 0;
    while (got < stop_at && budget < 3000) begin
      budget++;
      chk("rk_valid", rk_valid_o, 1);
      chk("rk_round", rk_round_o, got);
      chk("rk", rk_o, exp_rk[got]);
      chk("rk_last", rk_last_o, (got == 15));
      chk("busy", busy_o, 1);
      if (key_valid_i) chk("key_ready_emit", key_ready_o, 0);
      rk_ready_i = ($urandom_range(99) >= stall_pct);
      cap[got] = rk_o;
      @(posedge clk); #1;
      if (rk_ready_i) got++;
    end
    rk_ready_i = 1'b0;
    if (got < stop_at) chk("collect_timeout", got, stop_at);
  endtask

  task automatic finish_check();
    chk("end_valid", rk_valid_o, 0);
    chk("end_key_ready", key_ready_o, 1);
    chk("end_busy", busy_o, 0);
  endtask

  task automatic run(input logic [63:0] k, input bit dec, input int stall_pct);
    key_i = k;
    decrypt_i = dec;
    build(k, dec);
    accept();
    collect(16, stall_pct);
    finish_check();
  endtask

  initial begin
    logic [63:0] rkey;
    logic [63:0] other;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rk_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_last", rk_last_o, 0);
    chk("rst_rk", rk_o, 0);
    chk("rst_round", rk_round_o, 0);
    chk("rst_key_ready", key_ready_o, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer encrypt, no backpressure.
    run(TKEY, 1'b0, 0);
    for (int i = 0; i < 16; i++) cap_enc[i] = cap[i];
    chk("kat_enc_r0", cap[0], 48'h1B02EFFC7072);
    chk("kat_enc_r1", cap[1], 48'h79AED9DBC9E5);
    chk("kat_enc_r15", cap[15], 48'hCB3D8B0E17F5);
    @(posedge clk); #1;
    chk("idle_key_ready_2", key_ready_o, 1);

    // Decrypt must be the exact reverse.
    run(TKEY, 1'b1, 0);
    chk("kat_dec_r0", cap[0], 48'hCB3D8B0E17F5);
    chk("kat_dec_r14", cap[14], 48'h79AED9DBC9E5);
    chk("kat_dec_r15", cap[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_reverse", cap[i], cap_enc[15-i]);

    // Parity bits ignored.
    run(64'h0101010101010101, 1'b0, 0);
    for (int i = 0; i < 16; i++) chk("parity_01", cap[i], 48'h0);
    run(64'h0000000000000000, 1'b1, 0);
    for (int i = 0; i < 16; i++) chk("parity_00", cap[i], 48'h0);
    run(64'hFEFEFEFEFEFEFEFE, 1'b0, 0);
    for (int i = 0; i < 16; i++) chk("parity_fe", cap[i], 48'hFFFFFFFFFFFF);

    // Backpressure: same sequence as the unstalled run.
    run(TKEY, 1'b0, 30);
    for (int i = 0; i < 16; i++) chk("stall_seq", cap[i], cap_enc[i]);

    // Random keys, both directions, random stalls.
    for (int t = 0; t < 6; t++) begin
      rkey = {$urandom, $urandom};
      run(rkey, t[0], $urandom_range(40));
    end

    // A key offered during EMIT is ignored, then taken in IDLE.
    other = {$urandom, $urandom};
    key_i = TKEY;
    decrypt_i = 1'b0;
    build(TKEY, 1'b0);
    accept();
    key_valid_i = 1'b1;
    key_i = other;
    decrypt_i = 1'b1;
    collect(16, 20);
    chk("offer_idle_ready", key_ready_o, 1);
    build(other, 1'b1);
    accept();
    collect(16, 0);
    finish_check();

    // Reset during round 7, then a clean sequence.
    key_i = TKEY;
    decrypt_i = 1'b0;
    build(TKEY, 1'b0);
    accept();
    collect(7, 0);
    chk("pre_rst_round", rk_round_o, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", rk_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rk", rk_o, 0);
    chk("mid_rst_round", rk_round_o, 0);
    chk("mid_rst_key_ready", key_ready_o, 1);
    @(posedge clk); #1;
    chk("post_rst_idle_valid", rk_valid_o, 0);
    run(TKEY, 1'b0, 0);
    for (int i = 0; i < 16; i++) chk("post_rst_seq", cap[i], cap_enc[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
